// File: rtl/byte_fifo_stage_pkg.sv
// Shared types and helpers for the byte FIFO stage.
// Optional debug occupancy port is enabled by defining BYTE_FIFO_STAGE_LEVEL_EN.
package byte_fifo_stage_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [7:0] byte_t;

    // Pointer width for a power-of-two entry count.
    function automatic int ptr_w(int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/byte_fifo_stage_mem.sv
// DEPTH x 8 register array: cleared on reset, one write port, one combinational read port.
module byte_fifo_stage_mem
    import byte_fifo_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  byte_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output byte_t         rd_data_c
);

    byte_t mem_q [DEPTH];
    byte_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/byte_fifo_stage.sv
// First-word-fall-through byte FIFO feeding the capture register stage.
// Define BYTE_FIFO_STAGE_LEVEL_EN to expose the registered occupancy on `level`.
module byte_fifo_stage
    import byte_fifo_stage_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = unsigned'(ptr_w(int'(DEPTH))),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  byte_t            in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output byte_t            out_data
`ifdef BYTE_FIFO_STAGE_LEVEL_EN
    ,
    output logic [CNT_W-1:0] level
`endif
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_c, pop_c;
    byte_t            rd_data_c;

    // Handshake flags decode from registered count only.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push_c    = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    byte_fifo_stage_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push_c),
        .wr_addr   (wr_ptr_q),
        .wr_data   (in_data),
        .rd_addr   (rd_ptr_q),
        .rd_data_c (rd_data_c)
    );

    // Never expose stale array contents while empty.
    assign out_data = out_valid ? rd_data_c : 8'h00;

`ifdef BYTE_FIFO_STAGE_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_byte_fifo_stage.sv
// Self-checking bench for byte_fifo_stage: queue reference model plus directed and random traffic.
module tb_byte_fifo_stage;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef BYTE_FIFO_STAGE_LEVEL_EN
    logic [2:0] level;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];

    byte_fifo_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BYTE_FIFO_STAGE_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of at most DEPTH bytes, updated on the same edge as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit do_push = in_valid && (model_q.size() < DEPTH);
            automatic bit do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        check("m_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("m_out_data",  32'(out_data),  (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
`ifdef BYTE_FIFO_STAGE_LEVEL_EN
        check("m_level",     32'(level),     32'(model_q.size()));
`endif
    end

    initial begin
        logic [7:0] fill_vals [4];
        logic [7:0] drain_vals [4];
        int pop_at;
        fill_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_vals = '{8'h22, 8'h33, 8'h44, 8'h55};

        // Reset with the producer already offering a byte.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_out_valid", 32'(out_valid), 32'h0);
        tick();
        check("a5_valid", 32'(out_valid), 32'h1);
        check("a5_data",  32'(out_data),  32'hA5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("a5_popped", 32'(out_valid), 32'h0);

        // Fill to full with no consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fill_vals[i];
            check("fill_ready", 32'(in_ready), 32'h1);
            tick();
        end
        check("full_ready", 32'(in_ready), 32'h0);
        check("full_head",  32'(out_data), 32'h11);
        in_data = 8'h55;
        tick();
        check("held_ready", 32'(in_ready), 32'h0);
        check("held_head",  32'(out_data), 32'h11);

        // Pop while full with a pending push: push rejected, accepted on the next edge.
        out_ready = 1'b1;
        tick();
        check("fp_head",  32'(out_data), 32'h22);
        check("fp_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b0;
        tick();
        check("refill_ready", 32'(in_ready), 32'h0);
        check("refill_head",  32'(out_data), 32'h22);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(out_data), 32'(drain_vals[i]));
            tick();
        end
        check("drained_valid", 32'(out_valid), 32'h0);

        // Streaming 00..0F with both sides ready.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            if (i > 0) begin
                check("stream_valid", 32'(out_valid), 32'h1);
                check("stream_data",  32'(out_data),  32'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_last", 32'(out_data), 32'h0F);
        tick();
        check("stream_empty", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-cycle with three bytes stored.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_ready", 32'(in_ready),  32'h1);
        check("arst_data",  32'(out_data),  32'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_pop", 32'(out_valid), 32'h0);

        // Three pushes and one pop in random order (pop never first).
        pop_at = int'($urandom_range(1, 3));
        for (int op = 0, pushed = 0; op < 4; op++) begin
            if (op == pop_at) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end else begin
                in_valid  = 1'b1;
                in_data   = 8'hE0 + 8'(pushed);
                out_ready = 1'b0;
                pushed++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("lvl_valid", 32'(out_valid), 32'h1);
        check("lvl_head",  32'(out_data),  32'hE1);
`ifdef BYTE_FIFO_STAGE_LEVEL_EN
        check("lvl_end", 32'(level), 32'h2);
`endif

        // Random traffic obeying the hold-until-accepted producer rule.
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < DEPTH + 1; c++) tick();
        check("final_empty", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
